// File: rtl/regbank_arbiter.sv
// regbank_arbiter: two-port arbiter that sequences a bank of byte registers
// sharing one tristate read bus. It produces one-hot load strobes (ld) and
// one-hot output enables (oe), and leaves every output enable low for a bus
// turnaround gap after each read.
//
// Optional feature macro: REGBANK_LOCK_EN (adds a_lock / b_lock priority hold).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request (host/config)
//   a_done/a_err           port A completion / out-of-range pulses
//   b_*                    same set for port B (I2C engine)
//   rdata                  registered read data, valid while done pulses
//   ld                     one-hot register load strobe
//   oe                     one-hot register output enable
//   wdata                  write data broadcast to all registers
//   bus_rdata              shared tristate read bus
//   a_lock, b_lock         (REGBANK_LOCK_EN only) keep priority after done
module regbank_arbiter #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_done,
  output logic                a_err,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_done,
  output logic                b_err,
  output logic [DATA_W-1:0]   rdata,
  output logic [NUM_REGS-1:0] ld,
  output logic [NUM_REGS-1:0] oe,
  output logic [DATA_W-1:0]   wdata,
`ifdef REGBANK_LOCK_EN
  input  logic                a_lock,
  input  logic                b_lock,
`endif
  input  logic [DATA_W-1:0]   bus_rdata
);

  // Counter holds the number of TURN cycles still to go after the current one.
  localparam int unsigned CNT_W = (TURNAROUND > 2) ? $clog2(TURNAROUND - 1) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RDONE, TURN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cur_b_q, cur_b_d;    // granted port: 0=A, 1=B
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_b_q, last_b_d;  // last granted port
  logic                hold_q, hold_d;      // priority hold pending
  logic                hold_b_q, hold_b_d;  // port owning the hold

  logic [NUM_REGS-1:0] ld_d, oe_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d;
  logic                a_done_d, a_err_d, b_done_d, b_err_d;

  logic                pick_b, sel_we, sel_bad, lock_cur;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef REGBANK_LOCK_EN
  assign lock_cur = cur_b_q ? b_lock : a_lock;
`else
  assign lock_cur = 1'b0;
`endif

  // Arbitration: a held port wins a tie, otherwise the port not granted last.
  always_comb begin
    if (a_req && b_req) pick_b = hold_q ? hold_b_q : !last_b_q;
    else                pick_b = b_req;
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_bad   = 32'(sel_addr) >= NUM_REGS;
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_b_d  = cur_b_q;
    addr_d   = addr_q;
    last_b_d = last_b_q;
    hold_d   = hold_q;
    hold_b_d = hold_b_q;
    ld_d     = '0;
    oe_d     = '0;
    wdata_d  = wdata;
    rdata_d  = rdata;
    a_done_d = 1'b0;
    a_err_d  = 1'b0;
    b_done_d = 1'b0;
    b_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          cur_b_d = pick_b;
          addr_d  = sel_addr;
          hold_d  = 1'b0;
          // A grant taken by the hold owner does not rotate the round robin.
          if (!hold_q || (pick_b != hold_b_q)) last_b_d = pick_b;
          if (sel_bad) begin
            state_d  = RDONE;
            a_done_d = !pick_b;
            a_err_d  = !pick_b;
            b_done_d = pick_b;
            b_err_d  = pick_b;
          end else if (sel_we) begin
            state_d  = WR;
            ld_d     = NUM_REGS'(1) << sel_addr;
            wdata_d  = sel_wdata;
            a_done_d = !pick_b;
            b_done_d = pick_b;
          end else begin
            state_d = RD1;
            oe_d    = NUM_REGS'(1) << sel_addr;
          end
        end
      end
      WR: begin
        hold_d   = lock_cur;
        hold_b_d = cur_b_q;
        state_d  = IDLE;
      end
      RD1: begin
        oe_d    = NUM_REGS'(1) << addr_q;
        state_d = RD2;
      end
      RD2: begin
        rdata_d  = bus_rdata;
        a_done_d = !cur_b_q;
        b_done_d = cur_b_q;
        state_d  = RDONE;
      end
      RDONE: begin
        hold_d   = lock_cur;
        hold_b_d = cur_b_q;
        if (TURNAROUND > 1) begin
          cnt_d   = CNT_W'(TURNAROUND - 2);
          state_d = TURN;
        end else begin
          state_d = IDLE;
        end
      end
      TURN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_b_q  <= 1'b0;
      addr_q   <= '0;
      last_b_q <= 1'b1;
      hold_q   <= 1'b0;
      hold_b_q <= 1'b0;
      ld       <= '0;
      oe       <= '0;
      wdata    <= '0;
      rdata    <= '0;
      a_done   <= 1'b0;
      a_err    <= 1'b0;
      b_done   <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_b_q  <= cur_b_d;
      addr_q   <= addr_d;
      last_b_q <= last_b_d;
      hold_q   <= hold_d;
      hold_b_q <= hold_b_d;
      ld       <= ld_d;
      oe       <= oe_d;
      wdata    <= wdata_d;
      rdata    <= rdata_d;
      a_done   <= a_done_d;
      a_err    <= a_err_d;
      b_done   <= b_done_d;
      b_err    <= b_err_d;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: directed write/read/error/reset
// scenarios plus randomized single and dual-port traffic checked against a
// transaction-level model (register contents, round-robin owner, last rdata).
module tb_regbank_arbiter;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TA = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_done, a_err, b_done, b_err;
  logic [DW-1:0] rdata, wdata, bus_rdata;
  logic [NR-1:0] ld, oe;
`ifdef REGBANK_LOCK_EN
  logic          a_lock, b_lock;
`endif

  regbank_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .TURNAROUND(TA)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_err(b_err),
    .rdata(rdata), .ld(ld), .oe(oe), .wdata(wdata),
`ifdef REGBANK_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .bus_rdata(bus_rdata)
  );

  initial forever #5 clk = ~clk;

  // Register bank harness: loads on ld, drives the tristate bus on oe.
  logic [DW-1:0] regs [NR];
  logic          load_init;
  logic [DW-1:0] mem_m [NR];   // reference model of the register contents

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (load_init)  regs[i] <= mem_m[i];
      else if (ld[i]) regs[i] <= wdata;
    end
  end

  always_comb begin
    bus_rdata = 'z;
    if ($countones(oe) == 1) begin
      for (int i = 0; i < NR; i++) if (oe[i]) bus_rdata = regs[i];
    end else if (oe != '0) begin
      bus_rdata = 'x;
    end
  end

  typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] data; bit lock;} txn_t;
  typedef struct {bit port_b; logic err; logic [DW-1:0] rd; int cyc;
                  logic [NR-1:0] ld; logic [NR-1:0] oe; logic [DW-1:0] wd;} done_t;

  int      vectors, miscompares;
  bit      last_b_m;           // model: last granted port (1=B)
  logic [DW-1:0] rd_m;         // model: current rdata
  txn_t    qa[$], qb[$];
  done_t   dlog[$];
  bit      keep_a;
  int      min_gap, inv_bad, extra;

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the queued transactions of both ports with the req/done handshake
  // and logs every done pulse; starts and ends just after a rising edge.
  task automatic run_engine(input int budget, output bit timed_out);
    bit act_a, act_b, fin_a, fin_b, drop_a, drop_b, seen_oe;
    txn_t ca, cb;
    int cyc, gap, run;
    done_t d;
    act_a = 0; act_b = 0; fin_a = 0; fin_b = 0; seen_oe = 0;
    cyc = 0; gap = 0; run = 0; timed_out = 0;
    min_gap = 1000; inv_bad = 0; extra = 0;
    dlog.delete();
    ca = '{0, '0, '0, 0}; cb = '{0, '0, '0, 0};
    while (1) begin
      drop_a = 0; drop_b = 0;
      if (fin_a) begin
        fin_a = 0; act_a = 0;
        if (keep_a && qa.size() != 0) begin ca = qa.pop_front(); act_a = 1; end
        else drop_a = 1;
      end
      if (fin_b) begin fin_b = 0; act_b = 0; drop_b = 1; end
      if (!act_a && !drop_a && qa.size() != 0) begin ca = qa.pop_front(); act_a = 1; end
      if (!act_b && !drop_b && qb.size() != 0) begin cb = qb.pop_front(); act_b = 1; end
      a_req = act_a; a_we = ca.we; a_addr = ca.addr; a_wdata = ca.data;
      b_req = act_b; b_we = cb.we; b_addr = cb.addr; b_wdata = cb.data;
`ifdef REGBANK_LOCK_EN
      a_lock = act_a && ca.lock;
      b_lock = act_b && cb.lock;
`endif
      if (!act_a && !act_b && qa.size() == 0 && qb.size() == 0) break;
      if (cyc >= budget) begin timed_out = 1; break; end
      @(negedge clk);
      d.rd = rdata; d.cyc = cyc; d.ld = ld; d.oe = oe; d.wd = wdata;
      if (a_done) begin
        if (!act_a) extra++;
        else begin d.port_b = 0; d.err = a_err; dlog.push_back(d); fin_a = 1; end
      end
      if (b_done) begin
        if (!act_b) extra++;
        else begin d.port_b = 1; d.err = b_err; dlog.push_back(d); fin_b = 1; end
      end
      if ((a_err && !a_done) || (b_err && !b_done)) inv_bad++;
      if ($countones(oe) > 1 || $countones(ld) > 1 || (oe != '0 && ld != '0)) inv_bad++;
      if (oe != '0) begin
        if (seen_oe && gap > 0 && gap < min_gap) min_gap = gap;
        gap = 0; seen_oe = 1; run++;
        if (run > 2) inv_bad++;
      end else begin
        gap++; run = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_req = 0; b_req = 0;
`ifdef REGBANK_LOCK_EN
    a_lock = 0; b_lock = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1; load_init = 1; keep_a = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
`ifdef REGBANK_LOCK_EN
    a_lock = 0; b_lock = 0;
`endif
    for (int i = 0; i < NR; i++) mem_m[i] = DW'($urandom);
    @(posedge clk); #1 load_init = 0;
    @(negedge clk);
    vectors++; if (ld !== '0) begin miscompares++; $display("FAIL reset_ld: got %h exp 00", ld); end
    vectors++; if (oe !== '0) begin miscompares++; $display("FAIL reset_oe: got %h exp 00", oe); end
    vectors++; if (wdata !== '0) begin miscompares++; $display("FAIL reset_wdata: got %h exp 00", wdata); end
    vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h exp 00", rdata); end
    vectors++;
    if ({a_done, a_err, b_done, b_err} !== 4'b0) begin
      miscompares++; $display("FAIL reset_pulses: got %b exp 0000", {a_done, a_err, b_done, b_err});
    end
    rst = 0;
    last_b_m = 1; rd_m = '0;
    idle_cycles(1);
  endtask

  task automatic test_write();
    a_req = 1; a_we = 1; a_addr = AW'(2); a_wdata = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (a_done !== 1'b1) begin miscompares++; $display("FAIL wr_done: got %b exp 1", a_done); end
    vectors++; if (ld !== 8'b0000_0100) begin miscompares++; $display("FAIL wr_ld: got %b exp 00000100", ld); end
    vectors++; if (wdata !== 8'hA5) begin miscompares++; $display("FAIL wr_wdata: got %h exp a5", wdata); end
    vectors++; if (oe !== '0) begin miscompares++; $display("FAIL wr_oe: got %b exp 0", oe); end
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b exp 0", a_err); end
    @(posedge clk); #1 a_req = 0;
    @(negedge clk);
    vectors++; if (ld !== '0 || a_done !== 1'b0) begin
      miscompares++; $display("FAIL wr_one_cycle: got ld=%b done=%b exp 0/0", ld, a_done);
    end
    mem_m[2] = 8'hA5; last_b_m = 0;
    idle_cycles(2);
  endtask

  task automatic test_read();
    a_req = 1; a_we = 0; a_addr = AW'(2);
    @(posedge clk); @(negedge clk);
    vectors++; if (oe !== 8'b0000_0100 || a_done !== 1'b0) begin
      miscompares++; $display("FAIL rd_rd1: got oe=%b done=%b exp 00000100/0", oe, a_done);
    end
    @(posedge clk); @(negedge clk);
    vectors++; if (oe !== 8'b0000_0100 || a_done !== 1'b0 || ld !== '0) begin
      miscompares++; $display("FAIL rd_rd2: got oe=%b done=%b ld=%b exp 00000100/0/0", oe, a_done, ld);
    end
    @(posedge clk); @(negedge clk);
    vectors++; if (a_done !== 1'b1 || oe !== '0) begin
      miscompares++; $display("FAIL rd_done: got done=%b oe=%b exp 1/0", a_done, oe);
    end
    vectors++; if (rdata !== mem_m[2]) begin miscompares++; $display("FAIL rd_data: got %h exp %h", rdata, mem_m[2]); end
    @(posedge clk); #1 a_req = 0;
    @(negedge clk);
    vectors++; if (oe !== '0 || a_done !== 1'b0) begin
      miscompares++; $display("FAIL rd_turn: got oe=%b done=%b exp 0/0", oe, a_done);
    end
    rd_m = mem_m[2]; last_b_m = 0;
    idle_cycles(3);
  endtask

  task automatic test_err();
    b_req = 1; b_we = 0; b_addr = AW'(9);
    @(posedge clk); @(negedge clk);
    vectors++; if (b_done !== 1'b1 || b_err !== 1'b1) begin
      miscompares++; $display("FAIL err_pulse: got done=%b err=%b exp 1/1", b_done, b_err);
    end
    vectors++; if (ld !== '0 || oe !== '0 || a_done !== 1'b0) begin
      miscompares++; $display("FAIL err_strobes: got ld=%b oe=%b a_done=%b exp 0/0/0", ld, oe, a_done);
    end
    vectors++; if (rdata !== rd_m) begin miscompares++; $display("FAIL err_rdata: got %h exp %h", rdata, rd_m); end
    @(posedge clk); #1 b_req = 0;
    @(negedge clk);
    vectors++; if (b_done !== 1'b0 || b_err !== 1'b0) begin
      miscompares++; $display("FAIL err_one_cycle: got done=%b err=%b exp 0/0", b_done, b_err);
    end
    last_b_m = 1;
    idle_cycles(3);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    a_req = 1; a_we = 0; a_addr = AW'(2);
    @(posedge clk); @(posedge clk); @(negedge clk);
    vectors++; if (oe !== 8'b0000_0100) begin miscompares++; $display("FAIL rst_pre_oe: got %b exp 00000100", oe); end
    rst = 1; #1;
    vectors++; if (oe !== '0 || ld !== '0) begin
      miscompares++; $display("FAIL rst_mid_strobes: got oe=%b ld=%b exp 0/0", oe, ld);
    end
    vectors++; if ({a_done, b_done, rdata} !== '0) begin
      miscompares++; $display("FAIL rst_mid_outs: got done=%b%b rdata=%h exp 00/00", a_done, b_done, rdata);
    end
    a_req = 0;
    @(posedge clk); @(negedge clk); rst = 0;
    rd_m = '0; last_b_m = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (a_done !== 1'b0 || oe !== '0) begin
        miscompares++; $display("FAIL rst_no_done: got done=%b oe=%b exp 0/0", a_done, oe);
      end
    end
    @(posedge clk); #1;
    d = DW'($urandom);
    a_req = 1; a_we = 1; a_addr = AW'(5); a_wdata = d;
    @(posedge clk); @(negedge clk);
    vectors++; if (a_done !== 1'b1 || ld !== 8'b0010_0000) begin
      miscompares++; $display("FAIL rst_after_wr: got done=%b ld=%b exp 1/00100000", a_done, ld);
    end
    @(posedge clk); #1 a_req = 0;
    mem_m[5] = d; last_b_m = 0;
    idle_cycles(2);
  endtask

  // Randomized single-port traffic, including out-of-range addresses.
  task automatic test_random();
    txn_t t; bit pb, to, err; int lat; logic [NR-1:0] oh;
    for (int n = 0; n < 40; n++) begin
      pb = 1'($urandom_range(0, 1));
      t.we = 1'($urandom_range(0, 1)); t.addr = AW'($urandom_range(0, 10));
      t.data = DW'($urandom); t.lock = 0;
      if (pb) qb.push_back(t); else qa.push_back(t);
      keep_a = 0;
      run_engine(20, to);
      err = (t.addr >= AW'(NR));
      lat = (err || t.we) ? 1 : 3;
      oh = '0;
      if (!err && t.we) begin mem_m[t.addr[2:0]] = t.data; oh[t.addr[2:0]] = 1'b1; end
      if (!err && !t.we) rd_m = mem_m[t.addr[2:0]];
      last_b_m = pb;
      vectors++; if (to || dlog.size() != 1) begin
        miscompares++; $display("FAIL rnd_count %0d: got %0d dones timeout=%0d exp 1", n, dlog.size(), to);
      end
      vectors++; if (inv_bad != 0 || extra != 0) begin
        miscompares++; $display("FAIL rnd_invariant %0d: got bad=%0d extra=%0d exp 0", n, inv_bad, extra);
      end
      if (dlog.size() == 1) begin
        vectors++; if (dlog[0].port_b != pb || dlog[0].err !== err || dlog[0].cyc != lat) begin
          miscompares++;
          $display("FAIL rnd_done %0d: got port=%0d err=%b lat=%0d exp %0d/%b/%0d",
                   n, dlog[0].port_b, dlog[0].err, dlog[0].cyc, pb, err, lat);
        end
        vectors++; if (dlog[0].rd !== rd_m || dlog[0].ld !== oh || dlog[0].oe !== '0) begin
          miscompares++;
          $display("FAIL rnd_data %0d: got rd=%h ld=%b oe=%b exp %h/%b/0", n, dlog[0].rd, dlog[0].ld, dlog[0].oe, rd_m, oh);
        end
        if (!err && t.we) begin
          vectors++; if (dlog[0].wd !== t.data) begin
            miscompares++; $display("FAIL rnd_wdata %0d: got %h exp %h", n, dlog[0].wd, t.data);
          end
        end
      end
      idle_cycles(3);
    end
  endtask

  // Both ports request together; the tie goes to the port not granted last.
  task automatic test_rr();
    txn_t ta, tb2, tt; bit to, first_b, pb; logic [DW-1:0] exp_rd [2];
    for (int r = 0; r < 4; r++) begin
      ta.we  = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      tb2.we = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ta.addr  = AW'($urandom_range(0, NR - 1)); ta.data  = DW'($urandom); ta.lock = 0;
      tb2.addr = AW'($urandom_range(0, NR - 1)); tb2.data = DW'($urandom); tb2.lock = 0;
      qa.push_back(ta); qb.push_back(tb2); keep_a = 0;
      run_engine(40, to);
      first_b = !last_b_m;
      for (int k = 0; k < 2; k++) begin
        pb = (k == 0) ? first_b : !first_b;
        tt = pb ? tb2 : ta;
        if (tt.we) mem_m[tt.addr[2:0]] = tt.data;
        else rd_m = mem_m[tt.addr[2:0]];
        exp_rd[k] = rd_m;
      end
      last_b_m = !first_b;
      vectors++; if (to || dlog.size() != 2 || inv_bad != 0 || extra != 0) begin
        miscompares++;
        $display("FAIL rr_round %0d: got dones=%0d timeout=%0d bad=%0d extra=%0d exp 2/0/0/0",
                 r, dlog.size(), to, inv_bad, extra);
      end
      vectors++; if (min_gap < TA) begin
        miscompares++; $display("FAIL rr_gap %0d: got %0d exp >= %0d", r, min_gap, TA);
      end
      if (dlog.size() == 2) begin
        vectors++; if (dlog[0].port_b != first_b || dlog[1].port_b == first_b) begin
          miscompares++;
          $display("FAIL rr_order %0d: got %0d,%0d exp %0d,%0d", r, dlog[0].port_b, dlog[1].port_b, first_b, !first_b);
        end
        vectors++; if (dlog[0].cyc != ((first_b ? tb2.we : ta.we) ? 1 : 3) || dlog[1].cyc <= dlog[0].cyc) begin
          miscompares++; $display("FAIL rr_latency %0d: got %0d,%0d", r, dlog[0].cyc, dlog[1].cyc);
        end
        vectors++; if (dlog[0].rd !== exp_rd[0] || dlog[1].rd !== exp_rd[1]) begin
          miscompares++;
          $display("FAIL rr_rdata %0d: got %h,%h exp %h,%h", r, dlog[0].rd, dlog[1].rd, exp_rd[0], exp_rd[1]);
        end
      end
      idle_cycles(3);
    end
  endtask

`ifdef REGBANK_LOCK_EN
  // A keeps its request up and holds lock on the first transfer only.
  task automatic test_lock();
    txn_t t; bit to;
    t = '{1'b1, AW'(1), DW'($urandom), 1'b0};
    qb.push_back(t); keep_a = 0;
    run_engine(20, to);
    mem_m[1] = t.data; last_b_m = 1;
    idle_cycles(3);
    qa.push_back('{1'b1, AW'(3), 8'h11, 1'b1});
    qa.push_back('{1'b1, AW'(4), 8'h22, 1'b0});
    qb.push_back('{1'b1, AW'(6), 8'h33, 1'b0});
    keep_a = 1;
    run_engine(40, to);
    keep_a = 0;
    mem_m[3] = 8'h11; mem_m[4] = 8'h22; mem_m[6] = 8'h33; last_b_m = 1;
    vectors++; if (to || dlog.size() != 3) begin
      miscompares++; $display("FAIL lock_count: got %0d timeout=%0d exp 3", dlog.size(), to);
    end
    if (dlog.size() == 3) begin
      vectors++; if (dlog[0].port_b || dlog[1].port_b || !dlog[2].port_b) begin
        miscompares++;
        $display("FAIL lock_order: got %0d,%0d,%0d exp 0,0,1", dlog[0].port_b, dlog[1].port_b, dlog[2].port_b);
      end
    end
    idle_cycles(3);
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    test_reset();
    test_write();
    test_read();
    test_err();
    test_reset_mid();
    test_random();
    test_rr();
`ifdef REGBANK_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
